// File: rtl/grayscale_pkg.sv
// ----------------------------------------------------------------------------
// grayscale_pkg
// Shared constants and types for the RGB-to-luma window converter.
//   - channel width, luma weights (sum to 256), rounding constant and shift
//   - product / sum widths used by the per-pixel datapath
//   - rgb_t: one 24-bit pixel, packed as {r, g, b}
// ----------------------------------------------------------------------------
package grayscale_pkg;

    localparam int PIX_W   = 8;
    localparam int NUM_PIX = 9;

    localparam int W_R   = 77;
    localparam int W_G   = 150;
    localparam int W_B   = 29;
    localparam int ROUND = 128;
    localparam int SHIFT = 8;

    // 255 * weight fits in these widths without loss.
    localparam int PROD_R_W = 15;
    localparam int PROD_G_W = 16;
    localparam int PROD_B_W = 13;
    localparam int SUM_W    = 17;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    // Adds the half-up rounding term and drops the fractional byte.
    // Largest possible sum is 65408, so the truncation never loses a set bit.
    function automatic logic [PIX_W-1:0] round_shift(input logic [SUM_W-1:0] sum);
        logic [SUM_W-1:0] rounded;
        rounded = sum + SUM_W'(ROUND);
        return PIX_W'(rounded >> SHIFT);
    endfunction

endpackage

// File: rtl/gray_pixel_unit.sv
// ----------------------------------------------------------------------------
// gray_pixel_unit
// One pixel's two-stage luma path.
//   stage 1: registers the three weighted channel products
//   stage 2: registers the rounded, shifted sum
// Each stage's data registers load only when its enable (the valid bit that
// accompanies the data into that stage) is high; otherwise they hold.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   i_en_s1  in   load enable for stage-1 products (incoming valid)
//   i_en_s2  in   load enable for stage-2 result (stage-1 valid)
//   i_pix    in   rgb_t pixel
//   o_gray   out  8-bit luma
// ----------------------------------------------------------------------------
module gray_pixel_unit
    import grayscale_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en_s1,
    input  logic             i_en_s2,
    input  rgb_t             i_pix,
    output logic [PIX_W-1:0] o_gray
);

    logic [PROD_R_W-1:0] w_prod_r;
    logic [PROD_G_W-1:0] w_prod_g;
    logic [PROD_B_W-1:0] w_prod_b;
    logic [SUM_W-1:0]    w_sum;

    logic [PROD_R_W-1:0] r_prod_r;
    logic [PROD_G_W-1:0] r_prod_g;
    logic [PROD_B_W-1:0] r_prod_b;
    logic [PIX_W-1:0]    r_gray;

    assign w_prod_r = PROD_R_W'(i_pix.r) * PROD_R_W'(W_R);
    assign w_prod_g = PROD_G_W'(i_pix.g) * PROD_G_W'(W_G);
    assign w_prod_b = PROD_B_W'(i_pix.b) * PROD_B_W'(W_B);

    assign w_sum = SUM_W'(r_prod_r) + SUM_W'(r_prod_g) + SUM_W'(r_prod_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_r <= '0;
            r_prod_g <= '0;
            r_prod_b <= '0;
        end else if (i_en_s1) begin
            r_prod_r <= w_prod_r;
            r_prod_g <= w_prod_g;
            r_prod_b <= w_prod_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gray <= '0;
        end else if (i_en_s2) begin
            r_gray <= round_shift(w_sum);
        end
    end

    assign o_gray = r_gray;

endmodule

// File: rtl/grayscale_converter.sv
// ----------------------------------------------------------------------------
// grayscale_converter
// Converts a 3x3 window of RGB pixels (0 = top-left .. 8 = bottom-right,
// row-major) into nine 8-bit luma values, gray = (77R + 150G + 29B + 128) >> 8.
// Fully pipelined: one window per clock, 2-clock latency, no backpressure.
// Ports:
//   clk                      in   rising-edge clock
//   rst_n                    in   asynchronous active-low reset
//   in_valid                 in   window on the pixel inputs is valid
//   pixel_N_red/green/blue   in   8-bit channels of pixel N (N = 0..8)
//   out_valid                out  pixel_N_out holds a converted window
//   pixel_N_out              out  8-bit luma of pixel N (holds when invalid)
// ----------------------------------------------------------------------------
module grayscale_converter
    import grayscale_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] pixel_0_red,
    input  logic [PIX_W-1:0] pixel_0_green,
    input  logic [PIX_W-1:0] pixel_0_blue,
    input  logic [PIX_W-1:0] pixel_1_red,
    input  logic [PIX_W-1:0] pixel_1_green,
    input  logic [PIX_W-1:0] pixel_1_blue,
    input  logic [PIX_W-1:0] pixel_2_red,
    input  logic [PIX_W-1:0] pixel_2_green,
    input  logic [PIX_W-1:0] pixel_2_blue,
    input  logic [PIX_W-1:0] pixel_3_red,
    input  logic [PIX_W-1:0] pixel_3_green,
    input  logic [PIX_W-1:0] pixel_3_blue,
    input  logic [PIX_W-1:0] pixel_4_red,
    input  logic [PIX_W-1:0] pixel_4_green,
    input  logic [PIX_W-1:0] pixel_4_blue,
    input  logic [PIX_W-1:0] pixel_5_red,
    input  logic [PIX_W-1:0] pixel_5_green,
    input  logic [PIX_W-1:0] pixel_5_blue,
    input  logic [PIX_W-1:0] pixel_6_red,
    input  logic [PIX_W-1:0] pixel_6_green,
    input  logic [PIX_W-1:0] pixel_6_blue,
    input  logic [PIX_W-1:0] pixel_7_red,
    input  logic [PIX_W-1:0] pixel_7_green,
    input  logic [PIX_W-1:0] pixel_7_blue,
    input  logic [PIX_W-1:0] pixel_8_red,
    input  logic [PIX_W-1:0] pixel_8_green,
    input  logic [PIX_W-1:0] pixel_8_blue,
    output logic             out_valid,
    output logic [PIX_W-1:0] pixel_0_out,
    output logic [PIX_W-1:0] pixel_1_out,
    output logic [PIX_W-1:0] pixel_2_out,
    output logic [PIX_W-1:0] pixel_3_out,
    output logic [PIX_W-1:0] pixel_4_out,
    output logic [PIX_W-1:0] pixel_5_out,
    output logic [PIX_W-1:0] pixel_6_out,
    output logic [PIX_W-1:0] pixel_7_out,
    output logic [PIX_W-1:0] pixel_8_out
);

    rgb_t             w_pix  [NUM_PIX];
    logic [PIX_W-1:0] w_gray [NUM_PIX];

    // r_valid[0] travels with stage-1 data, r_valid[1] with stage-2 data.
    logic [1:0] r_valid;

    assign w_pix[0] = {pixel_0_red, pixel_0_green, pixel_0_blue};
    assign w_pix[1] = {pixel_1_red, pixel_1_green, pixel_1_blue};
    assign w_pix[2] = {pixel_2_red, pixel_2_green, pixel_2_blue};
    assign w_pix[3] = {pixel_3_red, pixel_3_green, pixel_3_blue};
    assign w_pix[4] = {pixel_4_red, pixel_4_green, pixel_4_blue};
    assign w_pix[5] = {pixel_5_red, pixel_5_green, pixel_5_blue};
    assign w_pix[6] = {pixel_6_red, pixel_6_green, pixel_6_blue};
    assign w_pix[7] = {pixel_7_red, pixel_7_green, pixel_7_blue};
    assign w_pix[8] = {pixel_8_red, pixel_8_green, pixel_8_blue};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 2'b00;
        end else begin
            r_valid <= {r_valid[0], in_valid};
        end
    end

    for (genvar gi = 0; gi < NUM_PIX; gi++) begin : g_pix
        gray_pixel_unit u_pix (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en_s1 (in_valid),
            .i_en_s2 (r_valid[0]),
            .i_pix   (w_pix[gi]),
            .o_gray  (w_gray[gi])
        );
    end

    assign out_valid   = r_valid[1];
    assign pixel_0_out = w_gray[0];
    assign pixel_1_out = w_gray[1];
    assign pixel_2_out = w_gray[2];
    assign pixel_3_out = w_gray[3];
    assign pixel_4_out = w_gray[4];
    assign pixel_5_out = w_gray[5];
    assign pixel_6_out = w_gray[6];
    assign pixel_7_out = w_gray[7];
    assign pixel_8_out = w_gray[8];

endmodule

// File: tb/tb_grayscale_converter.sv
module tb_grayscale_converter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] r [9];
    logic [7:0] g [9];
    logic [7:0] b [9];
    logic       out_valid;
    logic [7:0] q [9];

    int n_checks;
    int n_errors;

    // reference pipeline model used by run_cycle
    logic       m_pend_v;
    logic [7:0] m_pend [9];
    logic [7:0] m_hold [9];

    grayscale_converter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .pixel_0_red   (r[0]), .pixel_0_green (g[0]), .pixel_0_blue (b[0]),
        .pixel_1_red   (r[1]), .pixel_1_green (g[1]), .pixel_1_blue (b[1]),
        .pixel_2_red   (r[2]), .pixel_2_green (g[2]), .pixel_2_blue (b[2]),
        .pixel_3_red   (r[3]), .pixel_3_green (g[3]), .pixel_3_blue (b[3]),
        .pixel_4_red   (r[4]), .pixel_4_green (g[4]), .pixel_4_blue (b[4]),
        .pixel_5_red   (r[5]), .pixel_5_green (g[5]), .pixel_5_blue (b[5]),
        .pixel_6_red   (r[6]), .pixel_6_green (g[6]), .pixel_6_blue (b[6]),
        .pixel_7_red   (r[7]), .pixel_7_green (g[7]), .pixel_7_blue (b[7]),
        .pixel_8_red   (r[8]), .pixel_8_green (g[8]), .pixel_8_blue (b[8]),
        .out_valid     (out_valid),
        .pixel_0_out   (q[0]),
        .pixel_1_out   (q[1]),
        .pixel_2_out   (q[2]),
        .pixel_3_out   (q[3]),
        .pixel_4_out   (q[4]),
        .pixel_5_out   (q[5]),
        .pixel_6_out   (q[6]),
        .pixel_7_out   (q[7]),
        .pixel_8_out   (q[8])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_gray(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        int unsigned s;
        s = 77 * int'(rr) + 150 * int'(gg) + 29 * int'(bb) + 128;
        return 8'(s / 256);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int i, input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        r[i] = rr;
        g[i] = gg;
        b[i] = bb;
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 9; i++) set_pix(i, v, v, v);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] v);
        for (int i = 0; i < 9; i++) chk($sformatf("%s pix%0d", tag, i), 32'(q[i]), 32'(v));
    endtask

    task automatic model_reset();
        m_pend_v = 1'b0;
        for (int i = 0; i < 9; i++) begin
            m_pend[i] = 8'd0;
            m_hold[i] = 8'd0;
        end
    endtask

    // Inputs already driven; clocks once and checks outputs against the model.
    task automatic run_cycle(input string tag);
        logic       nv;
        logic [7:0] nd [9];
        nv = in_valid;
        for (int i = 0; i < 9; i++) nd[i] = ref_gray(r[i], g[i], b[i]);
        step();
        if (m_pend_v) begin
            for (int i = 0; i < 9; i++) m_hold[i] = m_pend[i];
        end
        chk({tag, " out_valid"}, 32'(out_valid), 32'(m_pend_v));
        for (int i = 0; i < 9; i++) chk($sformatf("%s pix%0d", tag, i), 32'(q[i]), 32'(m_hold[i]));
        m_pend_v = nv;
        for (int i = 0; i < 9; i++) m_pend[i] = nd[i];
    endtask

    initial begin
        logic [7:0] exp_mix [9];
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        set_all(8'd0);
        model_reset();

        // reset state
        #3;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk_all("reset", 8'd0);
        #9 rst_n = 1'b1;   // t=12, between edges

        // single window, all channels 90
        step();
        set_all(8'd90);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        set_all(8'd3);
        chk("gray90 lat1 out_valid", 32'(out_valid), 32'd0);
        step();
        chk("gray90 lat2 out_valid", 32'(out_valid), 32'd1);
        chk_all("gray90", 8'd90);
        step();
        chk("gray90 after out_valid", 32'(out_valid), 32'd0);
        chk_all("gray90 hold", 8'd90);

        // primaries, white, black, and a mixed colour
        set_pix(0, 8'd255, 8'd0,   8'd0);
        set_pix(1, 8'd0,   8'd255, 8'd0);
        set_pix(2, 8'd0,   8'd0,   8'd255);
        set_pix(3, 8'd255, 8'd255, 8'd255);
        set_pix(4, 8'd0,   8'd0,   8'd0);
        for (int i = 5; i < 9; i++) set_pix(i, 8'd10, 8'd200, 8'd30);
        exp_mix = '{8'd77, 8'd149, 8'd29, 8'd255, 8'd0, 8'd124, 8'd124, 8'd124, 8'd124};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("mix out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 9; i++) chk($sformatf("mix pix%0d", i), 32'(q[i]), 32'(exp_mix[i]));
        step();

        // back-to-back stream k = 0..255
        for (int cyc = 0; cyc <= 257; cyc++) begin
            if (cyc < 256) begin
                set_all(8'(cyc));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (cyc >= 1 && cyc <= 256) begin
                chk($sformatf("stream%0d out_valid", cyc - 1), 32'(out_valid), 32'd1);
                chk_all($sformatf("stream%0d", cyc - 1), 8'(cyc - 1));
            end
        end
        chk("stream drained out_valid", 32'(out_valid), 32'd0);
        chk_all("stream hold", 8'd255);

        // async reset with windows in flight
        set_all(8'd60);
        in_valid = 1'b1;
        step();
        set_all(8'd70);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk_all("midrst async", 8'd0);
        #3 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) run_cycle($sformatf("postrst%0d", i));

        // first window after reset: 2-cycle latency
        set_all(8'd33);
        in_valid = 1'b1;
        run_cycle("first_a");
        in_valid = 1'b0;
        run_cycle("first_b");
        run_cycle("first_c");

        // alternating valid with distinct data every cycle
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 4) ? ~c[0] : 1'b0;
            for (int i = 0; i < 9; i++) set_pix(i, 8'(40 * c + i), 8'(20 * c + 3), 8'(250 - 30 * c));
            run_cycle($sformatf("toggle%0d", c));
        end

        // random windows, mostly valid
        for (int c = 0; c < 10000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 9; i++)
                set_pix(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            run_cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
